// File: rtl/cpu_bus_timing_pkg.sv
// Shared clocking constants, the ns-to-cycle helper and the bus-timing output bundle
// for the PET bus timing generator.
package cpu_bus_timing_pkg;

   localparam int unsigned SYS_CLOCK_MHZ   = 64;
   localparam int unsigned CPU_CLOCK_MHZ   = 1;
   localparam int unsigned SLOT_CYCLES     = int'(SYS_CLOCK_MHZ / CPU_CLOCK_MHZ);
   localparam int unsigned T_ADDR_VALID_NS = 100;
   localparam int unsigned T_DATA_HOLD_NS  = 30;

   // Round up so a timing margin is never shortened by truncation.
   function automatic int unsigned ns_to_cycles(input int unsigned ns);
      return (ns * SYS_CLOCK_MHZ + 32'd999) / 32'd1000;
   endfunction

   typedef struct packed {
      logic slot_start;
      logic dma_grant;
      logic dma_done;
      logic phi2;
      logic addr_strobe;
      logic data_strobe;
   } bus_timing_t;

endpackage

// File: rtl/cpu_bus_timing.sv
// PET bus slot generator: splits each CPU cycle into a DMA half (phi1) and a
// 6502 half (phi2), with address/data latch strobes placed from ns constants.
module cpu_bus_timing #(
   parameter int unsigned SLOT_CYCLES     = cpu_bus_timing_pkg::SLOT_CYCLES,
   parameter int unsigned T_ADDR_VALID_NS = cpu_bus_timing_pkg::T_ADDR_VALID_NS,
   parameter int unsigned T_DATA_HOLD_NS  = cpu_bus_timing_pkg::T_DATA_HOLD_NS
) (
   input  logic wb_clock_i,
   input  logic wb_reset_i,
   input  logic cpu_en_i,
   input  logic dma_req_i,
   output logic slot_start_o,
   output logic dma_grant_o,
   output logic dma_done_o,
   output logic cpu_phi2_o,
   output logic cpu_addr_strobe_o,
   output logic cpu_data_strobe_o
);
   import cpu_bus_timing_pkg::*;

   localparam int unsigned HALF     = SLOT_CYCLES / 2;
   localparam int unsigned ADDR_CYC = ns_to_cycles(T_ADDR_VALID_NS);
   localparam int unsigned HOLD_CYC = ns_to_cycles(T_DATA_HOLD_NS);
   localparam int unsigned LAST     = SLOT_CYCLES - 1;
   localparam int unsigned ADDR_POS = HALF + ADDR_CYC;
   localparam int unsigned DATA_POS = SLOT_CYCLES - 1 - HOLD_CYC;
   localparam int unsigned CW       = $clog2(SLOT_CYCLES);

   if ((SLOT_CYCLES % 2) != 0 || SLOT_CYCLES < 16) begin : g_bad_slot
      $error("cpu_bus_timing: SLOT_CYCLES must be even and >= 16");
   end
   if (ADDR_POS >= DATA_POS) begin : g_bad_strobes
      $error("cpu_bus_timing: address strobe must precede data strobe");
   end

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          started_q;
   logic          run_q;
   logic          run_d;
   logic          grant_q;
   logic          grant_d;
   bus_timing_t   out_q;
   bus_timing_t   out_d;

   // Outputs are decoded from the next count so each registered output lines up with count_q.
   always_comb begin
      count_d = '0;
      run_d   = run_q;
      grant_d = grant_q;
      out_d   = '0;

      // The first edge out of reset starts slot 0 rather than advancing past it.
      if (started_q && count_q != CW'(LAST)) begin
         count_d = count_q + CW'(1);
      end

      // Latch run/grant only at slot start so phi2 and grant never glitch mid-slot.
      if (count_d == '0) begin
         run_d   = cpu_en_i;
         grant_d = dma_req_i;
      end

      out_d.slot_start  = (count_d == '0);
      out_d.dma_grant   = grant_d && (count_d >= CW'(1)) && (count_d <= CW'(HALF - 2));
      out_d.dma_done    = grant_d && (count_d == CW'(HALF - 1));
      out_d.phi2        = run_d && (count_d >= CW'(HALF));
      out_d.addr_strobe = run_d && (count_d == CW'(ADDR_POS));
      out_d.data_strobe = run_d && (count_d == CW'(DATA_POS));
   end

   always_ff @(posedge wb_clock_i) begin
      if (wb_reset_i) begin
         count_q   <= '0;
         started_q <= 1'b0;
         run_q     <= 1'b0;
         grant_q   <= 1'b0;
         out_q     <= '0;
      end else begin
         count_q   <= count_d;
         started_q <= 1'b1;
         run_q     <= run_d;
         grant_q   <= grant_d;
         out_q     <= out_d;
      end
   end

   assign slot_start_o      = out_q.slot_start;
   assign dma_grant_o       = out_q.dma_grant;
   assign dma_done_o        = out_q.dma_done;
   assign cpu_phi2_o        = out_q.phi2;
   assign cpu_addr_strobe_o = out_q.addr_strobe;
   assign cpu_data_strobe_o = out_q.data_strobe;

endmodule

// File: tb/tb_cpu_bus_timing.sv
// Bench for cpu_bus_timing: default instance plus a 32-cycle / 125 ns override,
// both checked every cycle against a slot-level behavioural model.
module tb_cpu_bus_timing;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic req;

   logic a_slot, a_grant, a_done, a_phi2, a_addr, a_data;
   logic b_slot, b_grant, b_done, b_phi2, b_addr, b_data;
   logic [5:0] obs_a, obs_b, exp_a, exp_b;

   int total = 0;
   int bad   = 0;
   int k;            // cycles since reset release, -1 while in reset
   bit run_m [2];
   bit grant_m [2];

   always #5 clk = ~clk;

   cpu_bus_timing u_a (
      .wb_clock_i(clk), .wb_reset_i(rst), .cpu_en_i(en), .dma_req_i(req),
      .slot_start_o(a_slot), .dma_grant_o(a_grant), .dma_done_o(a_done),
      .cpu_phi2_o(a_phi2), .cpu_addr_strobe_o(a_addr), .cpu_data_strobe_o(a_data)
   );

   cpu_bus_timing #(.SLOT_CYCLES(32), .T_ADDR_VALID_NS(125), .T_DATA_HOLD_NS(30)) u_b (
      .wb_clock_i(clk), .wb_reset_i(rst), .cpu_en_i(en), .dma_req_i(req),
      .slot_start_o(b_slot), .dma_grant_o(b_grant), .dma_done_o(b_done),
      .cpu_phi2_o(b_phi2), .cpu_addr_strobe_o(b_addr), .cpu_data_strobe_o(b_data)
   );

   assign obs_a = {a_slot, a_grant, a_done, a_phi2, a_addr, a_data};
   assign obs_b = {b_slot, b_grant, b_done, b_phi2, b_addr, b_data};

   function automatic int ceil_cycles(input int ns);
      int prod;
      int q;
      prod = ns * 64;
      q    = prod / 1000;
      if (q * 1000 < prod) q = q + 1;
      return q;
   endfunction

   // Expected {slot, grant, done, phi2, addr, data} for cycle kk of a slot of s cycles.
   function automatic logic [5:0] model(input int s, input int a_ns, input int d_ns,
                                        input int kk, input bit r, input bit g);
      int h;
      int c;
      logic [5:0] v;
      h = s / 2;
      v = '0;
      if (kk >= 0) begin
         c    = kk % s;
         v[5] = (c == 0);
         v[4] = g && c >= 1 && c <= h - 2;
         v[3] = g && c == h - 1;
         v[2] = r && c >= h;
         v[1] = r && c == h + ceil_cycles(a_ns);
         v[0] = r && c == s - 1 - ceil_cycles(d_ns);
      end
      return v;
   endfunction

   // Advance the model with the inputs sampled at the next edge, then wait to the sample point.
   task automatic step();
      int sl [2];
      sl[0] = 64;
      sl[1] = 32;
      if (rst) begin
         k = -1;
      end else begin
         k = k + 1;
         for (int d = 0; d < 2; d++) begin
            if (k % sl[d] == 0) begin
               run_m[d]   = en;
               grant_m[d] = req;
            end
         end
      end
      @(negedge clk);
      exp_a = model(64, 100, 30, k, run_m[0], grant_m[0]);
      exp_b = model(32, 125, 30, k, run_m[1], grant_m[1]);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (obs_a !== 6'b0 || obs_b !== 6'b0) begin
            bad++;
            $display("FAIL reset_zero cyc=%0d got a=%b b=%b want 000000", i, obs_a, obs_b);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 130; i++) begin
         step();
         total++;
         if (a_slot !== ((k % 64) == 0)) begin
            bad++;
            $display("FAIL reset_slot_start cyc=%0d got=%b want=%b", k, a_slot, (k % 64) == 0);
         end
         total++;
         if (obs_b !== exp_b) begin
            bad++;
            $display("FAIL reset_b cyc=%0d got=%b want=%b", k, obs_b, exp_b);
         end
      end
   endtask

   task automatic test_phi2_timing();
      en  = 1'b1;
      req = 1'b0;
      do_reset(3);
      for (int i = 0; i < 192; i++) begin
         step();
         total++;
         if (obs_a !== exp_a) begin
            bad++;
            $display("FAIL phi2_a cyc=%0d got=%b want=%b", k, obs_a, exp_a);
         end
         total++;
         if (obs_b !== exp_b) begin
            bad++;
            $display("FAIL phi2_b cyc=%0d got=%b want=%b", k, obs_b, exp_b);
         end
      end
   endtask

   task automatic test_late_dma();
      en  = 1'b1;
      req = 1'b0;
      do_reset(3);
      for (int i = 0; i < 200; i++) begin
         step();
         total++;
         if (obs_a !== exp_a) begin
            bad++;
            $display("FAIL late_dma_a cyc=%0d got=%b want=%b", k, obs_a, exp_a);
         end
         total++;
         if (obs_b !== exp_b) begin
            bad++;
            $display("FAIL late_dma_b cyc=%0d got=%b want=%b", k, obs_b, exp_b);
         end
         total++;
         if (a_grant && a_phi2) begin
            bad++;
            $display("FAIL late_dma_overlap cyc=%0d got grant=1 phi2=1 want not both", k);
         end
         if (k == 10) req = 1'b1;
         if (k == 95) req = 1'b0;
      end
   endtask

   task automatic test_cpu_halt();
      en  = 1'b1;
      req = 1'b0;
      do_reset(3);
      for (int i = 0; i < 230; i++) begin
         step();
         total++;
         if (obs_a !== exp_a) begin
            bad++;
            $display("FAIL cpu_halt_a cyc=%0d got=%b want=%b", k, obs_a, exp_a);
         end
         total++;
         if (obs_b !== exp_b) begin
            bad++;
            $display("FAIL cpu_halt_b cyc=%0d got=%b want=%b", k, obs_b, exp_b);
         end
         if (k == 40)  en = 1'b0;
         if (k == 100) en = 1'b1;
      end
   endtask

   task automatic test_reset_mid_grant();
      bit fired;
      int hold;
      fired = 1'b0;
      hold  = 0;
      en    = 1'b0;
      req   = 1'b1;
      do_reset(3);
      for (int i = 0; i < 200; i++) begin
         step();
         total++;
         if (obs_a !== exp_a) begin
            bad++;
            $display("FAIL mid_grant_a cyc=%0d got=%b want=%b", k, obs_a, exp_a);
         end
         total++;
         if (obs_b !== exp_b) begin
            bad++;
            $display("FAIL mid_grant_b cyc=%0d got=%b want=%b", k, obs_b, exp_b);
         end
         if (!fired && k == 80) begin
            fired = 1'b1;
            rst   = 1'b1;
         end else if (rst) begin
            hold++;
            if (hold == 3) rst = 1'b0;
         end
      end
      req = 1'b0;
   endtask

   task automatic test_random();
      do_reset(2);
      for (int i = 0; i < 3000; i++) begin
         step();
         total++;
         if (obs_a !== exp_a) begin
            bad++;
            $display("FAIL random_a cyc=%0d got=%b want=%b", k, obs_a, exp_a);
         end
         total++;
         if (obs_b !== exp_b) begin
            bad++;
            $display("FAIL random_b cyc=%0d got=%b want=%b", k, obs_b, exp_b);
         end
         total++;
         if ((a_grant && a_phi2) || (b_grant && b_phi2)) begin
            bad++;
            $display("FAIL random_overlap cyc=%0d got a=%b b=%b want no grant+phi2", k, obs_a, obs_b);
         end
         if ($urandom_range(0, 40) == 0) en = ~en;
         if ($urandom_range(0, 30) == 0) req = ~req;
         rst = ($urandom_range(0, 700) == 0);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      req = 1'b0;
      k   = -1;
      run_m   = '{1'b0, 1'b0};
      grant_m = '{1'b0, 1'b0};
      repeat (2) @(negedge clk);
      test_reset();
      test_phi2_timing();
      test_late_dma();
      test_cpu_halt();
      test_reset_mid_grant();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_bus_timing.md
Name: cpu_bus_timing

Overview:
- Master timing generator for the PET bus, fed by the 64 MHz system clock.
- Divides the system clock into fixed 1 µs slots. First half (phi1) is the DMA window for the SPI/Wishbone requester; second half (phi2) is the 6502 bus cycle.
- Emits a phi2 clock, an address-latch strobe and a data-latch strobe. All positions are derived from nanosecond timing constants via ns_to_cycles.
- Downstream consumers are the CPU interface, the RAM controller and the DMA arbiter.

Parameters:
- SLOT_CYCLES, 64 (= SYS_CLOCK_MHZ / CPU_CLOCK_MHZ): system cycles per CPU cycle. Must be even and ≥16, else $error at elaboration.
- T_ADDR_VALID_NS, 100: delay from phi2 rise to cpu_addr_strobe_o.
- T_DATA_HOLD_NS, 30: margin from cpu_data_strobe_o to end of slot.

Ports:
- wb_clock_i  in  1  system clock, 64 MHz.
- wb_reset_i  in  1  synchronous, active-high reset.
- cpu_en_i  in  1  CPU run enable. Sampled only at slot start.
- dma_req_i  in  1  DMA request, level.
- slot_start_o  out  1  one-cycle pulse at count 0.
- dma_grant_o  out  1  DMA owns the bus.
- dma_done_o  out  1  one-cycle pulse ending a granted DMA window.
- cpu_phi2_o  out  1  6502 phi2 clock.
- cpu_addr_strobe_o  out  1  one-cycle pulse: latch CPU address/RW.
- cpu_data_strobe_o  out  1  one-cycle pulse: latch/commit CPU data.

Behaviour:
- Derived constants:
  - HALF = SLOT_CYCLES/2.
  - ADDR_CYC = ns_to_cycles(T_ADDR_VALID_NS) = 7 at defaults.
  - HOLD_CYC = ns_to_cycles(T_DATA_HOLD_NS) = 2 at defaults.
  - $error unless HALF+ADDR_CYC < SLOT_CYCLES-1-HOLD_CYC.
- Counter count_q, width $clog2(SLOT_CYCLES):
  - Increments every cycle.
  - Wraps SLOT_CYCLES-1 → 0.
- Output timing:
  - All outputs are registered and aligned to count_q: "at count N" means the cycle in which count_q == N.
  - Cycle k after reset deassertion has count_q = k mod SLOT_CYCLES.
- Reset:
  - count_q = 0; all outputs 0; grant/enable latches cleared.
  - Reset asserted mid-slot forces every output to 0 on the next edge, including an active grant. No dma_done_o pulse is emitted for the aborted grant.
- Slot-start latches, updated when count_q wraps to 0:
  - run_q ← cpu_en_i.
  - grant_q ← dma_req_i.
  - Changes of either input mid-slot have no effect until the next slot start, so phi2 never glitches.
- slot_start_o: 1 at count 0 only.
- DMA window:
  - dma_grant_o = grant_q during counts 1..HALF-2; 0 otherwise.
  - dma_done_o pulses at count HALF-1 if grant_q.
  - Requester holds dma_req_i until dma_done_o.
  - A request dropped mid-window does not shorten the grant.
  - A request held continuously is granted every slot.
- CPU window, when run_q = 1:
  - cpu_phi2_o = 1 for counts HALF..SLOT_CYCLES-1.
  - cpu_addr_strobe_o at count HALF+ADDR_CYC (39 at defaults).
  - cpu_data_strobe_o at count SLOT_CYCLES-1-HOLD_CYC (61 at defaults).
- CPU window, when run_q = 0: phi2 and both CPU strobes stay 0 for the whole slot.
- DMA and CPU windows never overlap.
  - dma_grant_o and cpu_phi2_o are never both 1.
  - At least one idle cycle separates them (counts 0 and HALF-1 carry no grant).

Decomposition:
- common_pkg gains:
  - CPU_CLOCK_MHZ = 1.
  - SLOT_CYCLES = int'(SYS_CLOCK_MHZ / CPU_CLOCK_MHZ).
  - T_ADDR_VALID_NS and T_DATA_HOLD_NS defaults.
- Cycle conversion uses the existing ns_to_cycles; no new conversion code in the block.
- No sub-module. Counter, latches and decode are one module of roughly 120–160 lines.

Test Plan:
- Reset sequence: hold reset 5 cycles, release → all outputs 0 during reset; slot_start_o pulses at cycle 0, 64 and 128.
- Phi2/strobe timing: cpu_en_i = 1 constant → phi2 high in cycles 32..63 of each slot; addr strobe at 39 only; data strobe at 61 only; repeats for 3 slots.
- Late DMA request: raise dma_req_i at cycle 10 → no grant in slot 0; grant at cycles 65..94; done at 95; phi2 never overlaps grant.
- CPU halt: drop cpu_en_i at cycle 40 (mid-phi2) → slot 0 phi2 completes normally to cycle 63; slot 1 has no phi2 and no strobes. Re-raise at cycle 100 → phi2 resumes at cycle 160.
- Reset mid-grant: dma_req_i held, assert reset at cycle 80 → grant 0 from cycle 81; no done pulse; after release the counter restarts at 0 and grant follows at counts 1..30.
- Parameter override: SLOT_CYCLES = 32, T_ADDR_VALID_NS = 125 → addr strobe at count 16+8 = 24 (exact-multiple ceil check); data strobe at 29.
